// File: rtl/tagger_event_buffer.sv
// Tagger serializer front end: timestamps edge/wrap cycles with a
// free-running counter and queues them for a pop/empty consumer.
module tagger_event_buffer #(
  parameter int CHANNELS   = 8,
  parameter int BITS       = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [BITS*CHANNELS-1:0]   sample_subtimes,
  input  logic [CHANNELS-1:0]        sample_edges,
  input  logic                       out_pop,
  output logic [BITS*CHANNELS-1:0]   out_subtimes,
  output logic [CHANNELS-1:0]        out_edges,
  output logic [15:0]                out_counter,
  output logic                       out_rollover,
  output logic                       out_overflow,
  output logic                       out_empty,
  output logic [DEPTH_LOG2:0]        occupancy,
  output logic [15:0]                drop_count
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_OCC =
    {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef struct packed {
    logic [BITS*CHANNELS-1:0] subtimes;
    logic [CHANNELS-1:0]      edges;
    logic [15:0]              counter;
    logic                     rollover;
    logic                     overflow;
  } entry_t;

  entry_t                mem [DEPTH];
  logic [15:0]           counter;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  overflow_pending;

  logic                  wrap;
  logic                  push_req;
  logic                  pop_ok;
  logic                  accept;
  logic                  drop;
  logic [DEPTH_LOG2:0]   occ_next;
  entry_t                wr_entry;

  // Push/pop decisions and the entry built from this cycle's sample
  always_comb begin
    wrap     = (counter == 16'h0000);
    push_req = (enable && |sample_edges) || wrap;
    pop_ok   = out_pop && !out_empty;
    accept   = push_req && ((occupancy != FULL_OCC) || pop_ok);
    drop     = push_req && !accept;
    occ_next = occupancy;
    unique case ({accept, pop_ok})
      2'b10:   occ_next = occupancy + 1'b1;
      2'b01:   occ_next = occupancy - 1'b1;
      default: occ_next = occupancy;
    endcase
    wr_entry.subtimes = sample_subtimes;
    wr_entry.edges    = sample_edges & {CHANNELS{enable}};
    wr_entry.counter  = counter;
    wr_entry.rollover = wrap;
    wr_entry.overflow = overflow_pending;
  end

  // Storage array; stale contents are harmless once pointers reset
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= wr_entry;
  end

  // Counter, pointers, flags and the registered output entry
  always_ff @(posedge clk) begin
    if (rst) begin
      counter          <= '0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      occupancy        <= '0;
      out_empty        <= 1'b1;
      overflow_pending <= 1'b0;
      drop_count       <= '0;
      out_subtimes     <= '0;
      out_edges        <= '0;
      out_counter      <= '0;
      out_rollover     <= 1'b0;
      out_overflow     <= 1'b0;
    end else begin
      counter   <= counter + 16'd1;
      occupancy <= occ_next;
      out_empty <= (occ_next == '0);
      if (accept) begin
        wr_ptr           <= wr_ptr + 1'b1;
        overflow_pending <= 1'b0;
      end
      if (drop) begin
        overflow_pending <= 1'b1;
        if (drop_count != 16'hFFFF)
          drop_count <= drop_count + 16'd1;
      end
      if (pop_ok) begin
        rd_ptr       <= rd_ptr + 1'b1;
        out_subtimes <= mem[rd_ptr].subtimes;
        out_edges    <= mem[rd_ptr].edges;
        out_counter  <= mem[rd_ptr].counter;
        out_rollover <= mem[rd_ptr].rollover;
        out_overflow <= mem[rd_ptr].overflow;
      end
    end
  end

endmodule

// File: tb/tb_tagger_event_buffer.sv
// Randomized bench for tagger_event_buffer against a queue-based
// model of the event FIFO, plus directed full/empty/reset cases.
module tb_tagger_event_buffer;

  localparam int CH    = 8;
  localparam int B     = 8;
  localparam int DL    = 2;
  localparam int DEPTH = 4;
  localparam int W     = CH * B;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [W-1:0]  sample_subtimes;
  logic [CH-1:0] sample_edges;
  logic          out_pop;
  logic [W-1:0]  out_subtimes;
  logic [CH-1:0] out_edges;
  logic [15:0]   out_counter;
  logic          out_rollover;
  logic          out_overflow;
  logic          out_empty;
  logic [DL:0]   occupancy;
  logic [15:0]   drop_count;

  always #5 clk = ~clk;

  tagger_event_buffer #(
    .CHANNELS(CH), .BITS(B), .DEPTH_LOG2(DL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .sample_subtimes(sample_subtimes),
    .sample_edges(sample_edges),
    .out_pop(out_pop),
    .out_subtimes(out_subtimes),
    .out_edges(out_edges),
    .out_counter(out_counter),
    .out_rollover(out_rollover),
    .out_overflow(out_overflow),
    .out_empty(out_empty),
    .occupancy(occupancy),
    .drop_count(drop_count)
  );

  typedef struct {
    logic [W-1:0]  st;
    logic [CH-1:0] ed;
    logic [15:0]   cnt;
    logic          ro;
    logic          ov;
  } ent_t;

  ent_t q[$];
  ent_t m_out;
  int   m_cnt;
  bit   m_pend;
  int   m_drop;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit en,
                            input logic [CH-1:0] e,
                            input logic [W-1:0] st, input bit p);
    bit   req;
    bit   can_pop;
    bit   room;
    ent_t n;
    if (r) begin
      q.delete();
      m_out  = '{default: '0};
      m_cnt  = 0;
      m_pend = 0;
      m_drop = 0;
      return;
    end
    req     = (en && e != '0) || (m_cnt == 0);
    can_pop = p && q.size() > 0;
    room    = q.size() < DEPTH || can_pop;
    if (can_pop) m_out = q.pop_front();
    if (req) begin
      if (room) begin
        n.st  = st;
        n.ed  = en ? e : '0;
        n.cnt = m_cnt[15:0];
        n.ro  = (m_cnt == 0);
        n.ov  = m_pend;
        q.push_back(n);
        m_pend = 0;
      end else begin
        m_pend = 1;
        if (m_drop < 65535) m_drop++;
      end
    end
    m_cnt = (m_cnt + 1) % 65536;
  endtask

  task automatic compare_all();
    check("empty", out_empty, q.size() == 0);
    check("occ", occupancy, q.size());
    check("drops", drop_count, m_drop);
    check("subt", out_subtimes, m_out.st);
    check("edges", out_edges, m_out.ed);
    check("cnt", out_counter, m_out.cnt);
    check("roll", out_rollover, m_out.ro);
    check("ovf", out_overflow, m_out.ov);
  endtask

  task automatic cyc(input bit r, input bit en,
                     input logic [CH-1:0] e,
                     input logic [W-1:0] st, input bit p);
    rst             = r;
    enable          = en;
    sample_edges    = e;
    sample_subtimes = st;
    out_pop         = p;
    @(posedge clk);
    model_step(r, en, e, st, p);
    #1;
    compare_all();
  endtask

  function automatic logic [W-1:0] rnd_st();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [CH-1:0] rnd_edge();
    logic [CH-1:0] v;
    v = CH'($urandom);
    if (v == '0) v = 8'h80;
    return v;
  endfunction

  logic [W-1:0] st0;
  logic [15:0]  d0;
  logic [15:0]  sv_cnt;
  logic [CH-1:0] sv_ed;

  initial begin
    rst = 1'b1; enable = 1'b0; out_pop = 1'b0;
    sample_edges = '0; sample_subtimes = '0;
    cyc(1, 0, '0, '0, 0);
    cyc(1, 0, '0, '0, 0);
    check("rst_empty", out_empty, 1);
    check("rst_occ", occupancy, 0);
    check("rst_cnt", out_counter, 0);

    // wrap entry right after reset, then edge at counter 0x10
    cyc(0, 1, '0, '0, 0);
    check("wrap_occ", occupancy, 1);
    cyc(0, 1, '0, '0, 1);
    check("wrap_roll", out_rollover, 1);
    check("wrap_cnt", out_counter, 0);
    check("wrap_edges", out_edges, 0);
    while (m_cnt != 16) cyc(0, 1, '0, rnd_st(), 0);
    st0 = rnd_st();
    cyc(0, 1, 8'h05, st0, 0);
    cyc(0, 1, '0, '0, 1);
    check("t2_cnt", out_counter, 16'h0010);
    check("t2_edges", out_edges, 8'h05);
    check("t2_subt", out_subtimes, st0);
    check("t2_roll", out_rollover, 0);
    check("t2_ovf", out_overflow, 0);

    // overflow: wrap + 6 edges into a 4-deep FIFO
    cyc(1, 0, '0, '0, 0);
    cyc(0, 1, '0, '0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 1, rnd_edge(), rnd_st(), 0);
    check("t3_occ", occupancy, 4);
    check("t3_drop", drop_count, 3);
    for (int i = 0; i < 4; i++) cyc(0, 1, '0, '0, 1);
    cyc(0, 1, 8'h01, rnd_st(), 0);
    cyc(0, 1, '0, '0, 1);
    check("t3_ovf1", out_overflow, 1);
    cyc(0, 1, 8'h02, rnd_st(), 0);
    cyc(0, 1, '0, '0, 1);
    check("t3_ovf0", out_overflow, 0);

    // full FIFO with simultaneous edge and pop
    for (int i = 0; i < 4; i++) cyc(0, 1, rnd_edge(), rnd_st(), 0);
    check("t4_full", occupancy, 4);
    d0 = drop_count;
    cyc(0, 1, 8'h33, rnd_st(), 1);
    check("t4_occ", occupancy, 4);
    check("t4_drop", drop_count, d0);

    // pop held while empty
    for (int i = 0; i < 4; i++) cyc(0, 1, '0, '0, 1);
    sv_cnt = out_counter;
    sv_ed  = out_edges;
    for (int i = 0; i < 10; i++) cyc(0, 1, '0, '0, 1);
    check("t5_cnt", out_counter, sv_cnt);
    check("t5_edges", out_edges, sv_ed);
    check("t5_occ", occupancy, 0);
    check("t5_empty", out_empty, 1);

    // reset with entries stored
    for (int i = 0; i < 3; i++) cyc(0, 1, rnd_edge(), rnd_st(), 0);
    check("t6_pre", occupancy, 3);
    cyc(1, 1, '0, '0, 0);
    check("t6_empty", out_empty, 1);
    check("t6_occ", occupancy, 0);
    check("t6_drop", drop_count, 0);
    check("t6_out", out_edges, 0);
    cyc(0, 1, '0, '0, 0);
    cyc(0, 1, '0, '0, 1);
    check("t6_wrap", out_rollover, 1);
    check("t6_cnt", out_counter, 0);

    // randomized traffic with occasional resets
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(299) == 0), ($urandom_range(3) != 0),
          (($urandom_range(2) == 0) ? '0 : CH'($urandom)),
          rnd_st(), $urandom_range(1));
    end

    // full counter period: exactly the wrap entries appear
    cyc(1, 0, '0, '0, 0);
    for (int i = 0; i < 65540; i++) cyc(0, 1, '0, rnd_st(), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
